shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Multi-cycle shift/rotate unit for the 16-bit datapath. It complements the single-cycle combinational rotate_right/rotate_left blocks with a sequential engine. The engine covers rotates and shifts in both directions, moves one bit position per clock, and reports the last bit shifted out. It sits beside the ALU and is driven by the control FSM through a start/done handshake, so long shift amounts do not lengthen the critical path.

## Interface
Parameters:
- none (data width fixed at 16; amount field fixed at 4 bits)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  3  000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR (only with SHIFT_ASR_EN), 101–111 reserved
- n  input  16  shift amount; only n[3:0] used (amount k = n mod 16)
- value  input  16  operand; sampled with start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result/carry valid from this cycle
- result  output  16  registered result; holds until the next done
- carry  output  1  last bit shifted out (0 when k = 0)

## Operation
- State machine has three states: IDLE, SHIFT, DONE. Working register `w`, counter `cnt[3:0]`, latched `op_q`.
- IDLE, start=1:
  - Load w←value, cnt←n[3:0], op_q←op, internal carry←0.
  - Next state is DONE if cnt=0 or op is unsupported; otherwise SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT: each cycle shift w by one position per op_q, set carry←bit leaving w, and decrement cnt. When cnt reaches 0, go to DONE.
- Per-step rules:
  - ROR: w←{w[0],w[15:1]}, carry←w[0].
  - ROL: w←{w[14:0],w[15]}, carry←w[15].
  - LSR: w←{1'b0,w[15:1]}, carry←w[0].
  - LSL: w←{w[14:0],1'b0}, carry←w[15].
  - ASR: w←{w[15],w[15:1]}, carry←w[0].
- DONE:
  - done=1; result←w and carry output←internal carry, both registered at entry to DONE.
  - Next state is IDLE. start is ignored in DONE.
- Unsupported op (101–111, or 100 without the macro): result=value, carry=0, zero-shift latency.
- start while busy is ignored: no queuing, no effect on the operation in flight.
- value, n and op may change after acceptance without effect.

## Timing
- Acceptance edge is edge 0. done is high during the cycle following edge k, where k = effective amount (0 for unsupported ops). State returns to IDLE at edge k+1.
- Earliest next acceptance is edge k+2, so back-to-back throughput is one op per k+2 cycles.
- busy rises after edge 0 and falls after edge k+1.
- result and carry change only on entry to DONE and are stable otherwise.
- Reset values: busy=0, done=0, result=16'h0000, carry=0, state=IDLE, cnt=0, w=0.
- Reset mid-operation: immediate return to IDLE with the reset values above. No done pulse is produced for the aborted operation.

## Configuration
- Macro: SHIFT_ASR_EN.
- Defined: op 100 performs an arithmetic right shift (sign bit replicated), k cycles.
- Undefined: op 100 is reserved. It behaves as pass-through (result=value, carry=0, done after edge 0), and the sign-replication logic is not compiled.

## Test plan
- ROR, value=16'h8001, n=1 → done after edge 1, result=16'hC000, carry=1; busy low after edge 2.
- ROL, value=16'h1234, n=16'h0004 → done after edge 4, result=16'h2341, carry=1.
- LSL, value=16'h00F0, n=16'h0013 (k=3) → done after edge 3, result=16'h0780, carry=0. Also n=0 with value=16'hBEEF → done after edge 0, result=16'hBEEF, carry=0.
- ASR, value=16'h8000, n=3: with SHIFT_ASR_EN → result=16'hF000, carry=0, done after edge 3; without the macro → result=16'h8000, done after edge 0.
- LSR, value=16'hFFFF, n=8, with a second start pulsed at edges 2 and 9 (DONE) → both ignored; single done after edge 8, result=16'h00FF, carry=1. A start at edge 10 is accepted.
- ROR, value=16'hAAAA, n=10, rst asserted asynchronously mid-cycle after edge 5 → busy/done/result/carry go to 0 immediately with no done pulse. A new start after rst release completes normally.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Multi-cycle 16-bit shift/rotate engine: one bit position per clock, start/done handshake.
// Optional arithmetic right shift (op 100) is compiled in only when SHIFT_ASR_EN is defined.
module shift_unit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] n,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ROR = 3'd0;
    localparam logic [2:0] OP_ROL = 3'd1;
    localparam logic [2:0] OP_LSR = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        c_q, c_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic [16:0] stepped;

    // Only the low nibble of the amount matters (k = n mod 16).
    logic unused_n_hi;
    assign unused_n_hi = ^n[15:4];

    function automatic logic op_supported(input logic [2:0] o);
`ifdef SHIFT_ASR_EN
        return (o <= OP_ASR);
`else
        return (o <= OP_LSL);
`endif
    endfunction

    // One-position step; returns {bit_shifted_out, new_word}.
    function automatic logic [16:0] step(input logic [2:0] o, input logic [15:0] x);
        logic [16:0] r;
        r = {1'b0, x};
        case (o)
            OP_ROR:  r = {x[0],  x[0], x[15:1]};
            OP_ROL:  r = {x[15], x[14:0], x[15]};
            OP_LSR:  r = {x[0],  1'b0, x[15:1]};
            OP_LSL:  r = {x[15], x[14:0], 1'b0};
`ifdef SHIFT_ASR_EN
            OP_ASR:  r = {x[0],  x[15], x[15:1]};
`endif
            default: r = {1'b0, x};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            w_q      <= 16'h0000;
            cnt_q    <= 4'd0;
            op_q     <= 3'd0;
            c_q      <= 1'b0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
        stepped  = step(op_q, w_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d   = value;
                    cnt_d = n[3:0];
                    op_d  = op;
                    c_d   = 1'b0;
                    // Zero amount and unsupported ops finish without shifting.
                    if ((n[3:0] == 4'd0) || !op_supported(op)) begin
                        state_d  = DONE;
                        result_d = value;
                        carry_d  = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_d   = stepped[15:0];
                c_d   = stepped[16];
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = DONE;
                    result_d = stepped[15:0];
                    carry_d  = stepped[16];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: cycle-level reference model plus directed literal cases.
// Honors SHIFT_ASR_EN the same way as the design.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] n = 16'h0000;
    logic [15:0] value = 16'h0000;
    logic        busy, done, carry;
    logic [15:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state: one accepted operation in flight at most.
    logic        m_active = 1'b0;
    int          m_acc = 0;
    int          m_k = 0;
    logic [15:0] m_pres = 16'h0000;
    logic        m_pcar = 1'b0;
    logic [15:0] m_res = 16'h0000;
    logic        m_car = 1'b0;

    shift_unit_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .n      (n),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    function automatic logic ref_supported(input logic [2:0] o);
`ifdef SHIFT_ASR_EN
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
`else
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd2) || (o == 3'd3);
`endif
    endfunction

    function automatic int ref_k(input logic [2:0] o, input logic [15:0] nn);
        return ref_supported(o) ? int'(nn % 16) : 0;
    endfunction

    // Whole-amount result computed arithmetically: returns {carry, result}.
    function automatic logic [16:0] ref_op(input logic [2:0] o, input logic [15:0] v, input int k);
        logic [15:0] r;
        logic [15:0] t;
        logic        c;
        r = v;
        c = 1'b0;
        if (k != 0) begin
            case (o)
                3'd0: begin r = (v >> k) | (v << (16 - k)); t = v >> (k - 1); c = t[0];  end
                3'd1: begin r = (v << k) | (v >> (16 - k)); t = v << (k - 1); c = t[15]; end
                3'd2: begin r = v >> k;                     t = v >> (k - 1); c = t[0];  end
                3'd3: begin r = v << k;                     t = v << (k - 1); c = t[15]; end
`ifdef SHIFT_ASR_EN
                3'd4: begin r = 16'($signed(v) >>> k);     t = v >> (k - 1); c = t[0];  end
`endif
                default: begin r = v; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Edge index of the edge being processed is cyc+1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_acc    <= 0;
            m_k      <= 0;
            m_res    <= 16'h0000;
            m_car    <= 1'b0;
        end else if (m_active) begin
            if (cyc + 1 == m_acc + m_k) begin
                m_res <= m_pres;
                m_car <= m_pcar;
            end
            if (cyc + 1 == m_acc + m_k + 1) m_active <= 1'b0;
        end else if (start) begin
            m_active         <= 1'b1;
            m_acc            <= cyc + 1;
            m_k              <= ref_k(op, n);
            {m_pcar, m_pres} <= ref_op(op, value, ref_k(op, n));
            if (ref_k(op, n) == 0) {m_car, m_res} <= {1'b0, value};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model busy",   busy,   m_active);
        check("model done",   done,   m_active && (cyc == m_acc + m_k));
        check("model result", result, m_res);
        check("model carry",  carry,  m_car);
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic [15:0] nn,
                          input logic [15:0] v, input int exp_k,
                          input logic [15:0] er, input logic ec);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = o; n = nn; value = v;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); n = 16'($urandom); value = 16'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, exp_k);
        check({nm, " result"}, result, er);
        check({nm, " carry"}, carry, ec);
        @(posedge clk); #1;
        check({nm, " busy after"}, busy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 16'h0000);
        check("reset carry", carry, 1'b0);
        rst = 1'b0;

        run_op("ror", 3'd0, 16'h0001, 16'h8001, 1, 16'hC000, 1'b1);
        run_op("rol", 3'd1, 16'h0004, 16'h1234, 4, 16'h2341, 1'b1);
        run_op("lsl", 3'd3, 16'h0013, 16'h00F0, 3, 16'h0780, 1'b0);
        run_op("lsl n0", 3'd3, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 1'b0);
`ifdef SHIFT_ASR_EN
        run_op("asr", 3'd4, 16'h0003, 16'h8000, 3, 16'hF000, 1'b0);
`else
        run_op("asr off", 3'd4, 16'h0003, 16'h8000, 0, 16'h8000, 1'b0);
`endif
        run_op("reserved", 3'd6, 16'h0005, 16'h1357, 0, 16'h1357, 1'b0);

        // Starts at edge 2 (SHIFT) and edge 9 (DONE) must be ignored; edge 10 accepted.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd2; n = 16'h0008; value = 16'hFFFF;
        @(posedge clk); #1;
        for (int e = 1; e <= 10; e++) begin
            start = (e == 2) || (e == 9) || (e == 10);
            if (e == 10) begin
                op = 3'd0; n = 16'h0001; value = 16'h8001;
            end else begin
                op = 3'($urandom); n = 16'($urandom); value = 16'($urandom);
            end
            @(posedge clk); #1;
            if (e == 8) begin
                check("lsr done", done, 1'b1);
                check("lsr result", result, 16'h00FF);
                check("lsr carry", carry, 1'b1);
            end
            if (e == 9) check("lsr single done", done, 1'b0);
        end
        start = 1'b0;
        check("edge10 accepted busy", busy, 1'b1);
        @(posedge clk); #1;
        check("edge10 done", done, 1'b1);
        check("edge10 result", result, 16'hC000);
        @(posedge clk); #1;
        check("edge10 busy after", busy, 1'b0);

        // Asynchronous reset in the middle of a 10-step rotate.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; n = 16'h000A; value = 16'hAAAA;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 16'h0000);
        check("abort carry", carry, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            check("abort no done", done, 1'b0);
        end
        run_op("after rst", 3'd1, 16'h0004, 16'h1234, 4, 16'h2341, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom);
            n     = 16'($urandom);
            value = 16'($urandom);
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("final idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
